uart_word_rx: RTL and testbench
===============================

Name: uart_word_rx

Overview:
- Serial receive path for the CPU's UART link; the counterpart of the CPU's UART_TX transmitter.
- Deserialises 8N1 bytes from the UART_RX pin.
- Assembles four bytes, least-significant byte first, into one 32-bit word.
- Presents the word to the CPU core with a valid/ack handshake.
- Instantiated at top level between the UART_RX pad and the CPU core; runs on the board clock, not the divided CPU clock.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud).
- TIMEOUT_BITS, 64, idle bit-times after which a partially assembled word is discarded.

Ports:
- clock  in  1  board clock.
- n_reset  in  1  asynchronous active-low reset.
- uart_rx  in  1  raw serial line; idles high; asynchronous to clock.
- word_out  out  32  last completed word.
- word_valid  out  1  word_out holds an unconsumed word.
- word_ack  in  1  consumer takes the word.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, on the ports clock and n_reset.
- Reset values:
  - word_out=0, word_valid=0, frame_err=0, overrun=0.
  - FSM in IDLE, byte count=0, shift register=0.
  - Synchroniser flops preset to 1, so no false start bit on reset release.
- Input synchronisation: uart_rx passes through a 2-FF synchroniser. All decisions use the synchronised signal, which adds 2 cycles of latency.
- FSM states and transitions:
  - IDLE: a falling edge (sync=0) goes to START and clears the bit timer.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If the line is high, the start was false: return to IDLE with no side effects. If low, go to DATA with bit index 0.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit. Shift bits in LSB first. After bit 7, go to STOP.
  - STOP: sample at mid-bit.
    - High: the byte is good. Pass it to the word assembler and go to IDLE.
    - Low: pulse frame_err for 1 cycle, discard the byte, clear the byte count, and go to IDLE only after the line returns high (no break re-triggering).
- Word assembly:
  - A good byte k (k=0..3) is written to word bits [8k+7:8k] of the assembly register; the count then increments.
  - On byte 3, the count wraps to 0 and the word completes.
- Word completion, the cycle after the stop-bit sample of byte 3:
  - word_valid=0: load word_out and set word_valid.
  - word_valid=1 and word_ack=0 in that cycle: pulse overrun for 1 cycle. word_out and word_valid are unchanged and the new word is lost.
  - word_valid=1 and word_ack=1 in the same cycle: the ack consumes the old word, the new word loads, word_valid stays 1, no overrun.
- Handshake:
  - word_valid stays high, with word_out stable, until word_ack is sampled high.
  - word_valid clears on the next edge.
  - word_ack while word_valid=0 is ignored.
- Timeout: a counter runs while in IDLE with byte count≠0. After TIMEOUT_BITS*CLKS_PER_BIT cycles it clears the byte count silently, with no error pulse.
- Width rules: the bit timer is sized $clog2(CLKS_PER_BIT)+1; the timeout counter is sized to hold the full product. No arithmetic is performed on data.
- Reset mid-frame: immediate abort. Partial byte and partial word are lost; all outputs return to their reset values.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - DATA_BITS=8, BYTES_PER_WORD=4.
- One sub-module: uart_byte_rx. It contains the synchroniser, bit FSM and timer. Outputs: byte, byte_strobe, frame_err.
- The top of this block holds word assembly, handshake and timeout.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_BITS=4 in simulation):
- Send 0x78, 0x56, 0x34, 0x12 -> word_out=0x12345678, word_valid=1; it holds for 100 cycles without ack and clears the cycle after a 1-cycle ack.
- Drive uart_rx low for 2 cycles, then high -> FSM returns to IDLE; no strobe, no frame_err; a following 4-byte word 0xCAFEF00D is received correctly.
- Byte 1 sent with stop bit = 0 -> frame_err pulses once and the partial word is discarded; the next bytes EF, BE, AD, DE give word_out=0xDEADBEEF.
- Word 0x11111111 received, no ack, then word 0x22222222 sent -> overrun pulses exactly once; word_out stays 0x11111111.
- word_ack asserted in the exact completion cycle of a second word -> word_valid stays 1, word_out=new word, overrun=0.
- Two bytes sent, then idle for more than 4 bit-times, then four bytes 01, 02, 03, 04 -> word_out=0x04030201; separately, n_reset asserted mid-DATA -> all outputs 0, and the next full word is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART word receiver.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 byte deserialiser with input synchroniser, bit timer and bit FSM.
//   clock, n_reset : board clock, asynchronous active-low reset
//   uart_rx        : raw serial line (idles high)
//   data           : last received byte, valid while byte_strobe is high
//   byte_strobe    : one-cycle pulse on a good stop bit
//   frame_err      : one-cycle pulse on a bad stop bit
//   idle           : receiver is waiting for a start bit
module uart_byte_rx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 byte_strobe,
    output logic                 frame_err,
    output logic                 idle
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

    state_t                 state, state_n;
    logic                   s1, s2;
    logic [TW-1:0]          timer, timer_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   brk, brk_n;
    logic                   strobe_n, ferr_n;

    assign data = shreg;
    assign idle = (state == IDLE);

    always_comb begin
        state_n  = state;
        timer_n  = timer + TW'(1);
        idx_n    = idx;
        shreg_n  = shreg;
        brk_n    = brk;
        strobe_n = 1'b0;
        ferr_n   = 1'b0;
        case (state)
            // After a framing error the line must go high again before a new start is accepted.
            IDLE: begin
                timer_n = '0;
                if (brk) brk_n = ~s2;
                else if (!s2) state_n = START;
            end
            START: if (timer == HALF) begin
                timer_n = '0;
                idx_n   = '0;
                state_n = s2 ? IDLE : DATA;
            end
            DATA: if (timer == FULL) begin
                timer_n = '0;
                shreg_n = {s2, shreg[DATA_BITS-1:1]};
                idx_n   = idx + IW'(1);
                if (idx == IW'(DATA_BITS - 1)) state_n = STOP;
            end
            STOP: if (timer == FULL) begin
                state_n  = IDLE;
                strobe_n = s2;
                ferr_n   = ~s2;
                brk_n    = ~s2;
            end
            default: state_n = IDLE;
        endcase
    end

    // Synchroniser presets high so reset release never looks like a start bit.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            state       <= IDLE;
            timer       <= '0;
            idx         <= '0;
            shreg       <= '0;
            brk         <= 1'b0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            s1          <= uart_rx;
            s2          <= s1;
            state       <= state_n;
            timer       <= timer_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            brk         <= brk_n;
            byte_strobe <= strobe_n;
            frame_err   <= ferr_n;
        end
    end
endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: assembles four 8N1 bytes (LSB first) into a 32-bit word with valid/ack handshake.
//   clock, n_reset : board clock, asynchronous active-low reset
//   uart_rx        : raw serial line
//   word_out       : last completed word
//   word_valid     : word_out holds an unconsumed word
//   word_ack       : consumer takes the word
//   frame_err      : one-cycle pulse on a bad stop bit
//   overrun        : one-cycle pulse when a completed word is dropped
module uart_word_rx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                                clock,
    input  logic                                n_reset,
    input  logic                                uart_rx,
    output logic [DATA_BITS*BYTES_PER_WORD-1:0] word_out,
    output logic                                word_valid,
    input  logic                                word_ack,
    output logic                                frame_err,
    output logic                                overrun
);
    localparam int CW         = $clog2(BYTES_PER_WORD);
    localparam int AW         = DATA_BITS * (BYTES_PER_WORD - 1);
    localparam int TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TOW        = $clog2(TO_CYCLES + 1);

    logic [DATA_BITS-1:0] data;
    logic                 strobe, idle, last, timeout;
    logic [CW-1:0]        cnt;
    logic [AW-1:0]        asm_word;
    logic [TOW-1:0]       tcnt;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clock       (clock),
        .n_reset     (n_reset),
        .uart_rx     (uart_rx),
        .data        (data),
        .byte_strobe (strobe),
        .frame_err   (frame_err),
        .idle        (idle)
    );

    assign last    = (cnt == CW'(BYTES_PER_WORD - 1));
    assign timeout = (tcnt == TOW'(TO_CYCLES - 1));

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            cnt        <= '0;
            asm_word   <= '0;
            tcnt       <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (strobe) cnt <= cnt + CW'(1);
            if (strobe && !last) asm_word[{cnt, 3'b000} +: DATA_BITS] <= data;
            if (frame_err || timeout) cnt <= '0;
            // The final byte bypasses the assembly register straight into word_out.
            if (strobe && last) begin
                if (!word_valid || word_ack) begin
                    word_out   <= {data, asm_word};
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_ack) begin
                word_valid <= 1'b0;
            end
            tcnt <= (!idle || cnt == '0 || strobe || timeout) ? '0 : tcnt + TOW'(1);
        end
    end
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: directed and randomized self-checking bench for uart_word_rx.
module tb_uart_word_rx;
    localparam int C = 8;
    localparam int T = 4;

    logic        clock = 1'b0;
    logic        n_reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic        word_ack = 1'b0;
    logic [31:0] word_out;
    logic        word_valid, frame_err, overrun;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    uart_word_rx #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(T)) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .uart_rx    (uart_rx),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ack   (word_ack),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // Pulses last a full cycle, so each is seen by exactly one falling edge.
    always @(negedge clock) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One 8N1 frame; optionally holds word_ack across the edge just after the stop-bit sample.
    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1, input logic ack_last = 1'b0);
        uart_rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(C);
        end
        uart_rx = stop;
        if (ack_last) begin
            tick(C - 1);
            word_ack = 1'b1;
            tick(1);
            word_ack = 1'b0;
        end else begin
            tick(C);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic ack_last = 1'b0);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, ack_last && k == 3);
    endtask

    task automatic ack_pulse();
        word_ack = 1'b1;
        tick(1);
        word_ack = 1'b0;
    endtask

    logic [7:0]  pend[$];
    logic [31:0] exp_word, w;
    logic        exp_valid;
    int          exp_ov, ov0, fe0, r;
    logic [7:0]  b;

    initial begin
        tick(3);
        chk("reset_word", word_out, 32'h0);
        chk("reset_valid", {31'h0, word_valid}, 32'h0);
        chk("reset_pulses", {30'h0, frame_err, overrun}, 32'h0);
        n_reset = 1'b1;
        tick(5);

        send_word(32'h12345678);
        chk("word1", word_out, 32'h12345678);
        chk("word1_valid", {31'h0, word_valid}, 32'h1);
        tick(100);
        chk("hold_word", word_out, 32'h12345678);
        chk("hold_valid", {31'h0, word_valid}, 32'h1);
        ack_pulse();
        chk("ack_clears", {31'h0, word_valid}, 32'h0);

        uart_rx = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        tick(20);
        chk("false_start_valid", {31'h0, word_valid}, 32'h0);
        chk("false_start_fe", fe_cnt, 0);
        send_word(32'hCAFEF00D);
        chk("after_false_start", word_out, 32'hCAFEF00D);
        ack_pulse();

        send_byte(8'hAA);
        send_byte(8'h55, 1'b0);
        tick(20);
        chk("frame_err_once", fe_cnt, 1);
        chk("frame_err_valid", {31'h0, word_valid}, 32'h0);
        send_word(32'hDEADBEEF);
        chk("after_frame_err", word_out, 32'hDEADBEEF);
        chk("after_frame_err_valid", {31'h0, word_valid}, 32'h1);
        ack_pulse();

        send_word(32'h11111111);
        ov0 = ov_cnt;
        send_word(32'h22222222);
        tick(3);
        chk("overrun_once", ov_cnt - ov0, 1);
        chk("overrun_word", word_out, 32'h11111111);
        chk("overrun_valid", {31'h0, word_valid}, 32'h1);

        ov0 = ov_cnt;
        send_word(32'h33333333, 1'b1);
        chk("ack_complete_valid", {31'h0, word_valid}, 32'h1);
        chk("ack_complete_word", word_out, 32'h33333333);
        tick(2);
        chk("ack_complete_ov", ov_cnt - ov0, 0);
        ack_pulse();

        send_byte(8'h99);
        send_byte(8'h88);
        tick(60);
        send_word(32'h04030201);
        chk("timeout_word", word_out, 32'h04030201);
        chk("timeout_fe", fe_cnt, 1);

        uart_rx = 1'b0;
        tick(C + 3 * C);
        n_reset = 1'b0;
        #1;
        chk("midframe_reset_word", word_out, 32'h0);
        chk("midframe_reset_valid", {31'h0, word_valid}, 32'h0);
        chk("midframe_reset_pulses", {30'h0, frame_err, overrun}, 32'h0);
        uart_rx = 1'b1;
        tick(2);
        n_reset = 1'b1;
        tick(5);
        send_word(32'hA5C30F96);
        chk("after_reset_word", word_out, 32'hA5C30F96);
        ack_pulse();

        exp_word  = 32'hA5C30F96;
        exp_valid = 1'b0;
        exp_ov    = 0;
        ov0       = ov_cnt;
        fe0       = fe_cnt;
        for (int n = 0; n < 100; n++) begin
            b = 8'($urandom);
            send_byte(b);
            pend.push_back(b);
            if (pend.size() == 4) begin
                w = {pend[3], pend[2], pend[1], pend[0]};
                pend.delete();
                if (exp_valid) exp_ov++;
                else begin
                    exp_valid = 1'b1;
                    exp_word  = w;
                end
            end
            chk("rand_word", word_out, exp_word);
            chk("rand_valid", {31'h0, word_valid}, {31'h0, exp_valid});
            r = $urandom_range(0, 9);
            if (r < 3) begin
                ack_pulse();
                exp_valid = 1'b0;
                chk("rand_ack", {31'h0, word_valid}, 32'h0);
            end
            if (r == 9) begin
                tick(60);
                pend.delete();
            end else begin
                tick($urandom_range(1, 12));
            end
        end
        tick(3);
        chk("rand_overruns", ov_cnt - ov0, exp_ov);
        chk("rand_frame_errs", fe_cnt - fe0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
